memory_access: RTL
==================

# memory_access

Memory stage of the single-cycle Y86-64 datapath, directly downstream of `execute`. It takes `valE` from execute, plus `valA` and `valP` forwarded from decode and fetch. It performs at most one 64-bit data-memory read or write per instruction over a req/ack bus and returns `valM` and the instruction status. A three-state FSM sequences each access, with a bounds check, an access timeout, and a sticky halt after any non-AOK status.

## Interface
Parameters:
- `MEM_BYTES`, default `64'h2000`: data-memory size in bytes. Valid addresses are `0 ... MEM_BYTES-8`.
- `TIMEOUT`, default `16`: number of REQ cycles without ack or error before the access is aborted.

Ports:
- `clk_i` input 1: clock. All state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `start_i` input 1: begin the memory phase of one instruction. Sampled only in IDLE while not halted.
- `icode_i` input 4: instruction code (`0`=HALT … `B`=POPQ).
- `valE_i` input 64: ALU result from `execute`.
- `valA_i` input 64: register operand A from decode.
- `valP_i` input 64: next-PC value from fetch.
- `valM_o` output 64: read data. Updated only on a successful read.
- `done_o` output 1: one-cycle pulse; `valM_o`/`stat_o` are valid in this cycle.
- `busy_o` output 1: high in REQ and RESP.
- `stat_o` output 3: instruction status. `1`=AOK, `2`=HLT, `3`=ADR, `4`=INS.
- `mem_req_o` output 1: bus request.
- `mem_we_o` output 1: 1 = write, 0 = read.
- `mem_addr_o` output 64: byte address.
- `mem_wdata_o` output 64: write data.
- `mem_rdata_i` input 64: read data. Valid with `mem_ack_i`.
- `mem_ack_i` input 1: access complete.
- `mem_err_i` input 1: access failed.

## Operation
- Decode of the latched `icode`:
  - Read: MRMOVQ(5), POPQ(B), RET(9).
  - Write: RMMOVQ(4), PUSHQ(A), CALL(8).
  - No memory op: all other codes.
- Address: `valA` for POPQ/RET; `valE` for the other memory ops.
- Write data: `valP` for CALL; `valA` for RMMOVQ/PUSHQ.
- On `start_i` in IDLE, latch icode, address, wdata and direction into internal registers. Bus outputs are driven only from these registers.
- Status priority (first match wins):
  1. icode > B → INS
  2. icode = 0 → HLT
  3. memory op with address > `MEM_BYTES-8` (unsigned compare, no add, so there is no wrap) → ADR, and no bus request is issued
  4. bus error or timeout → ADR
  5. otherwise AOK
- FSM states:
  - IDLE: accept `start_i`. If the instruction is a memory op with a valid address → REQ; otherwise → RESP.
  - REQ: hold `mem_req_o`=1 with stable addr/we/wdata.
    - `mem_err_i` → RESP with ADR. Error wins if it coincides with ack.
    - else `mem_ack_i` → RESP with AOK, and capture `mem_rdata_i` into `valM_o` if the access is a read.
    - else if the cycle counter reaches `TIMEOUT` → RESP with ADR.
  - RESP: `done_o`=1 for exactly one cycle, update `stat_o`, then → IDLE.
- Sticky halt: after any RESP with `stat_o` ≠ AOK, `start_i` is ignored until reset.
- `start_i` outside IDLE is ignored (not queued).
- `valM_o` holds its previous value on writes, non-memory ops and failed reads.
- Reset (async, takes effect mid-access):
  - State → IDLE; `mem_req_o`, `done_o`, `busy_o` and `mem_we_o` → 0.
  - `valM_o`, `mem_addr_o` and `mem_wdata_o` → 0.
  - `stat_o` → AOK; halt flag cleared; timeout counter → 0.

## Timing
- `start_i` sampled at edge N:
  - Non-memory op or rejected address: RESP and `done_o` high in cycle N+1.
  - Memory op: `mem_req_o` rises in cycle N+1.
- Ack sampled at edge K: `mem_req_o` falls and `done_o` is high in cycle K+1. Minimum memory-op latency is 2 cycles from start to done.
- Ack may arrive in the first REQ cycle.
- Timeout counter:
  - Clears on entry to REQ and increments each REQ cycle without ack/err.
  - When it reaches `TIMEOUT` (16 REQ cycles with no ack), the FSM goes to RESP and `mem_req_o` drops.
- Back-to-back: the next `start_i` is accepted in the cycle after `done_o` (IDLE).
- `busy_o` is a registered decode of the state; it is never high in IDLE.

## Test plan
- After reset, read all outputs → `stat_o`=1, all other outputs 0. Then MRMOVQ with `valE`=`0x100`, memory acks on the 3rd REQ cycle with `0xDEADBEEF` → `mem_addr_o`=`0x100`, `mem_we_o`=0, `valM_o`=`0xDEADBEEF`, `done_o` 4 cycles after start, `stat_o`=AOK.
- CALL with `valE`=`0x1F8` and `valP`=`0x40`, immediate ack → write to `0x1F8` with data `0x40`; `done_o` 2 cycles after start; `valM_o` unchanged.
- RMMOVQ with `valE`=`0x1FF9` → no `mem_req_o` pulse, `done_o` in cycle N+1, `stat_o`=ADR. A subsequent `start_i` is ignored (`busy_o` stays 0); after reset, a NOP completes with AOK.
- POPQ with `valA`=`0x80` and the memory never responding → `mem_req_o` high for 16 cycles, then `done_o` with `stat_o`=ADR; `valM_o` unchanged.
- Ack and err asserted together on a read → `stat_o`=ADR and `valM_o` not updated. Separately, icode `0xC` → INS in cycle N+1, and icode `0` → HLT.
- `rst_i` asserted mid-REQ → `mem_req_o` drops the same cycle, without waiting for a clock edge; after release, the next access proceeds normally.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: Y86-64 memory stage issuing one 64-bit read/write per instruction over a req/ack bus,
// with a bounds check, an access timeout and a sticky halt after any non-AOK status.
module memory_access #(
    parameter logic [63:0] MEM_BYTES = 64'h2000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  icode_i,
    input  logic [63:0] valE_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valP_i,
    output logic [63:0] valM_o,
    output logic        done_o,
    output logic        busy_o,
    output logic [2:0]  stat_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_ack_i,
    input  logic        mem_err_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [63:0] MAX_ADDR = MEM_BYTES - 64'd8;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;

    state_t        state_q, state_d;
    logic [63:0]   addr_q, addr_d, wdata_q, wdata_d, valm_q, valm_d;
    logic          we_q, we_d, rd_q, rd_d, halt_q, halt_d, busy_q;
    logic [2:0]    stat_q, stat_d, start_stat;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          is_rd, is_wr, is_mem;
    logic [63:0]   addr_in, wdata_in;

    assign is_rd      = icode_i inside {4'h5, 4'h9, 4'hB};
    assign is_wr      = icode_i inside {4'h4, 4'h8, 4'hA};
    assign is_mem     = is_rd | is_wr;
    assign addr_in    = (icode_i == 4'h9 || icode_i == 4'hB) ? valA_i : valE_i;
    assign wdata_in   = (icode_i == 4'h8) ? valP_i : valA_i;
    assign start_stat = (icode_i > 4'hB) ? INS :
                        (icode_i == 4'h0) ? HLT :
                        (is_mem && addr_in > MAX_ADDR) ? ADR : AOK;
    assign cnt_inc    = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rd_d    = rd_q;
        stat_d  = stat_q;
        valm_d  = valm_q;
        cnt_d   = cnt_q;
        halt_d  = halt_q;
        case (state_q)
            IDLE: if (start_i && !halt_q) begin
                addr_d  = addr_in;
                wdata_d = wdata_in;
                we_d    = is_wr;
                rd_d    = is_rd;
                cnt_d   = '0;
                if (is_mem && start_stat == AOK) begin
                    state_d = REQ;
                end else begin
                    state_d = RESP;
                    stat_d  = start_stat;
                end
            end
            REQ: if (mem_err_i) begin
                state_d = RESP;
                stat_d  = ADR;
            end else if (mem_ack_i) begin
                state_d = RESP;
                stat_d  = AOK;
                valm_d  = rd_q ? mem_rdata_i : valm_q;
            end else begin
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d = RESP;
                    stat_d  = ADR;
                end
            end
            RESP: begin
                state_d = IDLE;
                halt_d  = halt_q | (stat_q != AOK);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rd_q    <= 1'b0;
            stat_q  <= AOK;
            valm_q  <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            stat_q  <= stat_d;
            valm_q  <= valm_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign mem_req_o   = (state_q == REQ);
    assign done_o      = (state_q == RESP);
    assign busy_o      = busy_q;
    assign stat_o      = stat_q;
    assign valM_o      = valm_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
endmodule
